// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver with line synchronizers, glitch filters, frame
// checking, E0/F0 prefix folding and a first-word-fall-through output FIFO.
module ps2_scan_fifo #(
  parameter int DEPTH      = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000,
  parameter int RAW_MODE   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [9:0]               data,
  output logic                     valid,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     frame_err,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_MAX    = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);

  // Synchronizer, filter and edge-detect state
  logic [1:0]    clkSync_q, dataSync_q;
  logic          filtClk_q, filtClk_d, filtData_q, filtData_d;
  logic [FW-1:0] clkCnt_q, clkCnt_d, dataCnt_q, dataCnt_d;
  logic          fall_q;

  // Frame receiver state
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] toCnt_q, toCnt_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          pushValid_q, pushValid_d;
  logic [9:0]    pushData_q, pushData_d;
  logic          frameErr_q, frameErr_d;
  logic [7:0]    errCnt_q, errCnt_d;
  logic          reject;

  // FIFO state
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic          doPush, doPop, doWrite, doDrop, isFull;

  // Two-flop synchronizers; idle PS/2 lines are high so they reset to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
    end
  end

  // Filters flip only after FILTER_LEN consecutive samples disagree with them
  always_comb begin
    filtClk_d  = filtClk_q;
    clkCnt_d   = '0;
    filtData_d = filtData_q;
    dataCnt_d  = '0;
    if (clkSync_q[1] != filtClk_q) begin
      if (clkCnt_q == FILT_MAX) filtClk_d = clkSync_q[1];
      else                      clkCnt_d  = clkCnt_q + 1'b1;
    end
    if (dataSync_q[1] != filtData_q) begin
      if (dataCnt_q == FILT_MAX) filtData_d = dataSync_q[1];
      else                       dataCnt_d  = dataCnt_q + 1'b1;
    end
  end

  // Filter registers plus a one-cycle strobe on each filtered clock fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtClk_q  <= 1'b1;
      filtData_q <= 1'b1;
      clkCnt_q   <= '0;
      dataCnt_q  <= '0;
      fall_q     <= 1'b0;
    end else begin
      filtClk_q  <= filtClk_d;
      filtData_q <= filtData_d;
      clkCnt_q   <= clkCnt_d;
      dataCnt_q  <= dataCnt_d;
      fall_q     <= filtClk_q & ~filtClk_d;
    end
  end

  // Frame assembly, validity check, timeout abandonment and prefix folding
  always_comb begin
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    toCnt_d     = toCnt_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    pushValid_d = 1'b0;
    pushData_d  = pushData_q;
    frameErr_d  = 1'b0;
    errCnt_d    = errCnt_q;
    reject      = 1'b0;
    if (fall_q) begin
      toCnt_d = '0;
      if (bitCnt_q == 4'd10) begin
        bitCnt_d = 4'd0;
        if (shift_q[0] || !(^shift_q[9:1]) || !filtData_q) begin
          reject = 1'b1;
        end else if (RAW_MODE != 0) begin
          pushValid_d = 1'b1;
          pushData_d  = {2'b00, shift_q[8:1]};
        end else if (shift_q[8:1] == 8'hE0) begin
          ext_d = 1'b1;
        end else if (shift_q[8:1] == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          pushValid_d = 1'b1;
          pushData_d  = {ext_q, brk_q, shift_q[8:1]};
          ext_d       = 1'b0;
          brk_d       = 1'b0;
        end
      end else begin
        shift_d  = {filtData_q, shift_q[9:1]};
        bitCnt_d = bitCnt_q + 4'd1;
      end
    end else if (bitCnt_q != 4'd0) begin
      if (toCnt_q == TIMEOUT_MAX) begin
        bitCnt_d = 4'd0;
        toCnt_d  = '0;
        reject   = 1'b1;
      end else begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end else begin
      toCnt_d = '0;
    end
    if (reject) begin
      frameErr_d = 1'b1;
      ext_d      = 1'b0;
      brk_d      = 1'b0;
      if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
    end
  end

  // Receiver registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitCnt_q    <= 4'd0;
      shift_q     <= '0;
      toCnt_q     <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      pushValid_q <= 1'b0;
      pushData_q  <= '0;
      frameErr_q  <= 1'b0;
      errCnt_q    <= 8'd0;
    end else begin
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      toCnt_q     <= toCnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      pushValid_q <= pushValid_d;
      pushData_q  <= pushData_d;
      frameErr_q  <= frameErr_d;
      errCnt_q    <= errCnt_d;
    end
  end

  // A full FIFO still accepts a byte when the head leaves in the same cycle
  always_comb begin
    doPush  = pushValid_q;
    doPop   = valid & ready;
    isFull  = (level_q == FULL_LEVEL);
    doWrite = doPush & (~isFull | doPop);
    doDrop  = doPush & isFull & ~doPop;
  end

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr_q] <= pushData_q;
  end

  // Pointers wrap naturally at DEPTH; overflow is sticky until cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)   rdPtr_q <= rdPtr_q + 1'b1;
      if (doWrite && !doPop)      level_q <= level_q + 1'b1;
      else if (!doWrite && doPop) level_q <= level_q - 1'b1;
      if (doDrop)            overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  // Head is shown directly; an empty FIFO presents zero
  always_comb begin
    valid     = (level_q != '0);
    data      = valid ? mem[rdPtr_q] : 10'd0;
    level     = level_q;
    overflow  = overflow_q;
    frame_err = frameErr_q;
    err_count = errCnt_q;
  end

endmodule
